// File: rtl/result_drain.sv
// Parallel-in, serial-out drain: takes one row of els_p results per handshake
// and streams them out one element per beat, back-to-back rows without bubbles.
module result_drain #(
  parameter int width_p = 16,
  parameter int els_p   = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       valid_i,
  input  logic [els_p*width_p-1:0]   data_i,
  output logic                       ready_o,
  output logic                       valid_o,
  output logic [width_p-1:0]         data_o,
  output logic                       last_o,
  input  logic                       ready_i
);

  localparam int cnt_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [cnt_w_lp-1:0] last_idx_lp = cnt_w_lp'(els_p - 1);

  localparam logic [0:0] idle_s = 1'b0;
  localparam logic [0:0] send_s = 1'b1;

  logic [0:0]                          state_r;
  logic [cnt_w_lp-1:0]                 count_r;
  logic [els_p-1:0][width_p-1:0]       row_r;
  logic [width_p-1:0]                  elem;
  logic                                sending;
  logic                                row_xfer;

  assign sending = (state_r == send_s);

  generate
    if (els_p == 1) begin : g_single
      assign elem = row_r[0];
    end else begin : g_multi
      assign elem = row_r[count_r];
    end
  endgenerate

  assign valid_o  = sending;
  assign last_o   = sending && (count_r == last_idx_lp);
  assign data_o   = sending ? elem : '0;
  // Downstream ready feeds straight through so the next row lands on the last beat.
  assign ready_o  = !sending || (last_o && ready_i);
  assign row_xfer = valid_i && ready_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= idle_s;
      count_r <= '0;
      row_r   <= '0;
    end else if (row_xfer) begin
      state_r <= send_s;
      count_r <= '0;
      row_r   <= data_i;
    end else if (sending && ready_i) begin
      if (last_o) begin
        state_r <= idle_s;
        count_r <= '0;
      end else begin
        count_r <= count_r + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: a 4x16 instance for the main scenarios and
// a 1x8 instance for the single-element row case.
module tb_result_drain;

  logic        clk;
  logic        reset_i;
  logic        ready_i;

  logic        valid_i;
  logic [63:0] data_i;
  logic        ready_o;
  logic        valid_o;
  logic [15:0] data_o;
  logic        last_o;

  logic        valid1_i;
  logic [7:0]  data1_i;
  logic        ready1_o;
  logic        valid1_o;
  logic [7:0]  data1_o;
  logic        last1_o;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] row_a = {16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [63:0] row_b = {16'd8, 16'd7, 16'd6, 16'd5};

  result_drain #(.width_p(16), .els_p(4)) u_dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .valid_i (valid_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .last_o  (last_o),
    .ready_i (ready_i)
  );

  result_drain #(.width_p(8), .els_p(1)) u_dut1 (
    .clk_i   (clk),
    .reset_i (reset_i),
    .valid_i (valid1_i),
    .data_i  (data1_i),
    .ready_o (ready1_o),
    .valid_o (valid1_o),
    .data_o  (data1_o),
    .last_o  (last1_o),
    .ready_i (ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_i = 1'b1; valid_i = 1'b0; data_i = '0; ready_i = 1'b1;
    valid1_i = 1'b0; data1_i = '0;
    @(negedge clk);
    total++; if (valid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", valid_o); end
    total++; if (last_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_last: got %b want 0", last_o); end
    total++; if (data_o !== 16'h0) begin bad++; $display("[TB] FAIL reset_data: got %h want 0000", data_o); end
    total++; if (ready_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b want 1", ready_o); end
    next_cycle();
    reset_i = 1'b0;
  endtask

  task automatic test_single_row;
    valid_i = 1'b1; data_i = row_a;
    @(negedge clk);
    total++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin bad++; $display("[TB] FAIL single_pre: ready=%b valid=%b want ready=1 valid=0", ready_o, valid_o); end
    next_cycle();
    valid_i = 1'b0; data_i = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (valid_o !== 1'b1) begin bad++; $display("[TB] FAIL single_valid[%0d]: got %b want 1", k, valid_o); end
      total++; if (data_o !== 16'(k + 1)) begin bad++; $display("[TB] FAIL single_data[%0d]: got %0d want %0d", k, data_o, k + 1); end
      total++; if (last_o !== (k == 3)) begin bad++; $display("[TB] FAIL single_last[%0d]: got %b want %b", k, last_o, (k == 3)); end
      next_cycle();
    end
    @(negedge clk);
    total++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin bad++; $display("[TB] FAIL single_idle: valid=%b ready=%b want 0/1", valid_o, ready_o); end
    next_cycle();
  endtask

  task automatic test_back_to_back;
    valid_i = 1'b1; data_i = row_a;
    next_cycle();
    data_i = row_b;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total++; if (valid_o !== 1'b1 || data_o !== 16'(k + 1)) begin bad++; $display("[TB] FAIL b2b_beat[%0d]: valid=%b data=%0d want 1/%0d", k, valid_o, data_o, k + 1); end
      total++; if (ready_o !== (k == 3 || k == 7)) begin bad++; $display("[TB] FAIL b2b_ready[%0d]: got %b want %b", k, ready_o, (k == 3 || k == 7)); end
      total++; if (last_o !== (k == 3 || k == 7)) begin bad++; $display("[TB] FAIL b2b_last[%0d]: got %b want %b", k, last_o, (k == 3 || k == 7)); end
      next_cycle();
      if (k == 3) begin
        valid_i = 1'b0; data_i = '0;
      end
    end
    @(negedge clk);
    total++; if (valid_o !== 1'b0) begin bad++; $display("[TB] FAIL b2b_idle: got %b want 0", valid_o); end
    next_cycle();
  endtask

  task automatic test_backpressure;
    valid_i = 1'b1; data_i = row_a;
    next_cycle();
    valid_i = 1'b0; data_i = '0;
    @(negedge clk);
    total++; if (data_o !== 16'd1) begin bad++; $display("[TB] FAIL bp_first: got %0d want 1", data_o); end
    next_cycle();
    ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (valid_o !== 1'b1 || data_o !== 16'd2) begin bad++; $display("[TB] FAIL bp_hold[%0d]: valid=%b data=%0d want 1/2", k, valid_o, data_o); end
      total++; if (ready_o !== 1'b0 || last_o !== 1'b0) begin bad++; $display("[TB] FAIL bp_flags[%0d]: ready=%b last=%b want 0/0", k, ready_o, last_o); end
      next_cycle();
    end
    ready_i = 1'b1;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      total++; if (valid_o !== 1'b1 || data_o !== 16'(k + 1) || last_o !== (k == 3)) begin bad++; $display("[TB] FAIL bp_resume[%0d]: valid=%b data=%0d last=%b want 1/%0d/%b", k, valid_o, data_o, last_o, k + 1, (k == 3)); end
      next_cycle();
    end
    @(negedge clk);
    total++; if (valid_o !== 1'b0) begin bad++; $display("[TB] FAIL bp_idle: got %b want 0", valid_o); end
    next_cycle();
  endtask

  task automatic test_midframe_input;
    valid_i = 1'b1; data_i = row_a;
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      data_i = (k == 3) ? row_b : {4{16'hDEAD ^ 16'(k)}};
      @(negedge clk);
      total++; if (data_o !== 16'(k + 1)) begin bad++; $display("[TB] FAIL mid_data[%0d]: got %0d want %0d", k, data_o, k + 1); end
      total++; if (ready_o !== (k == 3)) begin bad++; $display("[TB] FAIL mid_ready[%0d]: got %b want %b", k, ready_o, (k == 3)); end
      next_cycle();
    end
    valid_i = 1'b0; data_i = {4{16'hBEEF}};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (valid_o !== 1'b1 || data_o !== 16'(k + 5)) begin bad++; $display("[TB] FAIL mid_rowb[%0d]: valid=%b data=%0d want 1/%0d", k, valid_o, data_o, k + 5); end
      next_cycle();
    end
    data_i = '0;
    @(negedge clk);
    total++; if (valid_o !== 1'b0) begin bad++; $display("[TB] FAIL mid_idle: got %b want 0", valid_o); end
    next_cycle();
  endtask

  task automatic test_async_reset;
    valid_i = 1'b1; data_i = row_a;
    next_cycle();
    valid_i = 1'b0; data_i = '0;
    next_cycle();
    @(negedge clk);
    total++; if (data_o !== 16'd2) begin bad++; $display("[TB] FAIL ar_before: got %0d want 2", data_o); end
    #1 reset_i = 1'b1;
    #1;
    total++; if (valid_o !== 1'b0 || last_o !== 1'b0 || data_o !== 16'h0) begin bad++; $display("[TB] FAIL ar_outputs: valid=%b last=%b data=%h want 0/0/0000", valid_o, last_o, data_o); end
    total++; if (ready_o !== 1'b1) begin bad++; $display("[TB] FAIL ar_ready: got %b want 1", ready_o); end
    next_cycle();
    reset_i = 1'b0;
    valid_i = 1'b1; data_i = row_b;
    next_cycle();
    valid_i = 1'b0; data_i = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (valid_o !== 1'b1 || data_o !== 16'(k + 5) || last_o !== (k == 3)) begin bad++; $display("[TB] FAIL ar_after[%0d]: valid=%b data=%0d last=%b want 1/%0d/%b", k, valid_o, data_o, last_o, k + 5, (k == 3)); end
      next_cycle();
    end
  endtask

  task automatic test_single_element;
    ready_i = 1'b1;
    valid1_i = 1'b1; data1_i = 8'hAA;
    @(negedge clk);
    total++; if (ready1_o !== 1'b1 || valid1_o !== 1'b0) begin bad++; $display("[TB] FAIL one_pre: ready=%b valid=%b want 1/0", ready1_o, valid1_o); end
    next_cycle();
    data1_i = 8'h55;
    @(negedge clk);
    total++; if (valid1_o !== 1'b1 || data1_o !== 8'hAA || last1_o !== 1'b1) begin bad++; $display("[TB] FAIL one_aa: valid=%b data=%h last=%b want 1/aa/1", valid1_o, data1_o, last1_o); end
    total++; if (ready1_o !== 1'b1) begin bad++; $display("[TB] FAIL one_ready: got %b want 1", ready1_o); end
    next_cycle();
    valid1_i = 1'b0; data1_i = '0;
    @(negedge clk);
    total++; if (valid1_o !== 1'b1 || data1_o !== 8'h55 || last1_o !== 1'b1) begin bad++; $display("[TB] FAIL one_55: valid=%b data=%h last=%b want 1/55/1", valid1_o, data1_o, last1_o); end
    next_cycle();
    @(negedge clk);
    total++; if (valid1_o !== 1'b0 || data1_o !== 8'h00) begin bad++; $display("[TB] FAIL one_idle: valid=%b data=%h want 0/00", valid1_o, data1_o); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_back_to_back();
    test_backpressure();
    test_midframe_input();
    test_async_reset();
    test_single_element();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
